// File: rtl/led_pkg.sv
// Shared types and helpers for the multi-channel LED pattern generator.
// Optional breathing PWM is enabled by defining LED_BREATHE_EN.
package led_pkg;

  // Per-channel config fields are held at this fixed width so the struct can
  // live in the package. Upper bits above PER_BITS/PWM_BITS stay zero and are pruned.
  localparam int LED_FIELD_W = 16;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_PWM   = 2'd3
  } led_mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } breathe_dir_e;

  typedef struct packed {
    led_mode_e              mode;
    logic [LED_FIELD_W-1:0] period;
    logic [LED_FIELD_W-1:0] duty;
  } led_cfg_t;

  function automatic int presc_terminal(input int clk_hz, input int tick_hz);
    return (clk_hz / tick_hz) - 1;
  endfunction

endpackage

// File: rtl/led_pattern_gen_channel.sv
// One LED channel: config registers, blink phase counter, output level and,
// when LED_BREATHE_EN is defined, the breathing duty FSM.
module led_channel
  import led_pkg::*;
#(
  parameter int PER_BITS = 10,
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  input  logic                wr_en,
  input  led_cfg_t            wr_cfg,
  output logic                level
);

  led_cfg_t               cfg_q, cfg_d;
  logic [PER_BITS-1:0]    cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic [LED_FIELD_W-1:0] blink_last;

`ifdef LED_BREATHE_EN
  localparam logic [LED_FIELD_W-1:0] DUTY_MAX = LED_FIELD_W'((1 << PWM_BITS) - 1);

  breathe_dir_e        dir_q, dir_d;
  logic [PER_BITS-1:0] step_q, step_d;
  logic                step_up;
`endif

  // A period of zero behaves as one tick per half-cycle.
  assign blink_last = (cfg_q.period == '0) ? '0 : cfg_q.period - LED_FIELD_W'(1);

  always_comb begin
    cfg_d   = cfg_q;
    cnt_d   = cnt_q;
    level_d = level_q;
`ifdef LED_BREATHE_EN
    dir_d   = dir_q;
    step_d  = step_q;
    step_up = 1'b0;
`endif
    if (wr_en) begin
      // A write restarts the channel's phase; any tick in this cycle is dropped.
      cfg_d   = wr_cfg;
      cnt_d   = '0;
      level_d = 1'b0;
`ifdef LED_BREATHE_EN
      dir_d   = DIR_UP;
      step_d  = '0;
`endif
    end else begin
      case (cfg_q.mode)
        MODE_OFF: level_d = 1'b0;
        MODE_ON:  level_d = 1'b1;
        MODE_BLINK: begin
          if (tick) begin
            if (LED_FIELD_W'(cnt_q) == blink_last) begin
              cnt_d   = '0;
              level_d = ~level_q;
            end else begin
              cnt_d = cnt_q + PER_BITS'(1);
            end
          end
        end
        MODE_PWM: begin
          level_d = (LED_FIELD_W'(pwm_cnt) < cfg_q.duty);
`ifdef LED_BREATHE_EN
          if (tick && (cfg_q.period != '0)) begin
            if (LED_FIELD_W'(step_q) == cfg_q.period - LED_FIELD_W'(1)) begin
              step_d  = '0;
              // Reverse at either end even if the start duty sits on the rail.
              step_up = ((dir_q == DIR_UP) && (cfg_q.duty != DUTY_MAX)) ||
                        ((dir_q == DIR_DOWN) && (cfg_q.duty == '0));
              if (step_up) begin
                cfg_d.duty = cfg_q.duty + LED_FIELD_W'(1);
                dir_d      = (cfg_d.duty == DUTY_MAX) ? DIR_DOWN : DIR_UP;
              end else begin
                cfg_d.duty = cfg_q.duty - LED_FIELD_W'(1);
                dir_d      = (cfg_d.duty == '0) ? DIR_UP : DIR_DOWN;
              end
            end else begin
              step_d = step_q + PER_BITS'(1);
            end
          end
`endif
        end
        default: level_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_q   <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
`ifdef LED_BREATHE_EN
      dir_q   <= DIR_UP;
      step_q  <= '0;
`endif
    end else begin
      cfg_q   <= cfg_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
`ifdef LED_BREATHE_EN
      dir_q   <= dir_d;
      step_q  <= step_d;
`endif
    end
  end

  assign level = level_q;

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel LED driver: shared tick prescaler, shared PWM counter, config
// address decode and output polarity. Define LED_BREATHE_EN for breathing PWM.
module led_pattern_gen
  import led_pkg::*;
#(
  parameter int CLK_HZ         = 27000000,
  parameter int TICK_HZ        = 1000,
  parameter int NUM_CH         = 6,
  parameter int PER_BITS       = 10,
  parameter int PWM_BITS       = 8,
  parameter int LED_ACTIVE_LOW = 1,
  localparam int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [1:0]          cfg_mode,
  input  logic [PER_BITS-1:0] cfg_period,
  input  logic [PWM_BITS-1:0] cfg_duty,
  output logic                tick_o,
  output logic [NUM_CH-1:0]   led
);

  localparam int PRESC_TERM = presc_terminal(CLK_HZ, TICK_HZ);
  localparam int PRESC_W    = (PRESC_TERM > 0) ? $clog2(PRESC_TERM + 1) : 1;

  logic [PRESC_W-1:0]  presc_q, presc_d;
  logic                tick_q, tick_d;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;
  logic [NUM_CH-1:0]   led_q, led_d;
  logic [NUM_CH-1:0]   level;
  logic                wr_fire;
  led_cfg_t            wr_cfg;

  assign cfg_ready = ~rst;
  assign wr_fire   = cfg_valid & cfg_ready;

  always_comb begin
    wr_cfg.mode   = led_mode_e'(cfg_mode);
    wr_cfg.period = LED_FIELD_W'(cfg_period);
    wr_cfg.duty   = LED_FIELD_W'(cfg_duty);
  end

  always_comb begin
    tick_d  = (presc_q == PRESC_W'(PRESC_TERM));
    presc_d = tick_d ? '0 : presc_q + PRESC_W'(1);
    pwm_d   = pwm_q + PWM_BITS'(1);
    led_d   = (LED_ACTIVE_LOW != 0) ? ~level : level;
  end

  // Channel indices at or above NUM_CH match no channel, so those writes vanish.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic wr_en;
    assign wr_en = wr_fire && (cfg_ch == CH_W'(gi));

    led_channel #(
      .PER_BITS (PER_BITS),
      .PWM_BITS (PWM_BITS)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .tick    (tick_q),
      .pwm_cnt (pwm_q),
      .wr_en   (wr_en),
      .wr_cfg  (wr_cfg),
      .level   (level[gi])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
      pwm_q   <= '0;
      led_q   <= (LED_ACTIVE_LOW != 0) ? '1 : '0;
    end else begin
      presc_q <= presc_d;
      tick_q  <= tick_d;
      pwm_q   <= pwm_d;
      led_q   <= led_d;
    end
  end

  assign tick_o = tick_q;
  assign led    = led_q;

endmodule
